// File: rtl/muldiv_unit_if.sv
// ----------------------------------------------------------------------------
// muldiv_unit_if
//   Handshake/operand bundle between the control path and the iterative
//   RV32M multiply/divide unit.
//
//   Request  (master -> slave): start, funct3, op1, op2, rd_in
//   Response (slave -> master): busy, done, regwrite, result, rd_out
//
//   master : control path / issue logic
//   slave  : muldiv_unit
// ----------------------------------------------------------------------------
interface muldiv_unit_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic              start;
    logic [2:0]        funct3;
    logic [WIDTH-1:0]  op1;
    logic [WIDTH-1:0]  op2;
    logic [ADDR_W-1:0] rd_in;

    logic              busy;
    logic              done;
    logic              regwrite;
    logic [WIDTH-1:0]  result;
    logic [ADDR_W-1:0] rd_out;

    modport master (
        output start, funct3, op1, op2, rd_in,
        input  busy, done, regwrite, result, rd_out
    );

    modport slave (
        input  start, funct3, op1, op2, rd_in,
        output busy, done, regwrite, result, rd_out
    );
endinterface

// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide execution unit. Accepts two register-file
//   operands plus a destination index, runs a WIDTH-cycle shift-add multiply
//   or restoring divide, and returns a registered write-back result with a
//   one-cycle done/regwrite strobe.
//
//   Ports
//     clk  : system clock, rising edge
//     rst  : asynchronous, active-low reset
//     bus  : muldiv_unit_if.slave
//              start/funct3/op1/op2/rd_in  request (start sampled in IDLE)
//              busy                         high whenever not IDLE
//              done, regwrite               one-cycle result-valid strobe
//              result, rd_out               registered write-back data/index
// ----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_REM    = 3'b110;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              r_state;
    logic [2:0]          r_op;
    logic [ADDR_W-1:0]   r_rd;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_busy;
    logic                r_done;
    logic [WIDTH-1:0]    r_result;
    logic                r_neg_q;
    logic                r_neg_r;
    logic [2*WIDTH-1:0]  r_prod;
    logic [WIDTH-1:0]    r_mcand;
    logic [WIDTH-1:0]    r_quo;
    logic [WIDTH-1:0]    r_dvs;
    logic [WIDTH:0]      r_rem;

    // Operand decode at accept
    logic                w_is_div;
    logic                w_s1;
    logic                w_s2;
    logic [WIDTH-1:0]    w_mag1;
    logic [WIDTH-1:0]    w_mag2;
    logic                w_div0;
    logic                w_ovf;

    always_comb begin
        w_is_div = bus.funct3[2];
        w_s1 = ((bus.funct3 == F3_MULH) || (bus.funct3 == F3_MULHSU) ||
                (bus.funct3 == F3_DIV)  || (bus.funct3 == F3_REM)) && bus.op1[WIDTH-1];
        w_s2 = ((bus.funct3 == F3_MULH) || (bus.funct3 == F3_DIV) ||
                (bus.funct3 == F3_REM)) && bus.op2[WIDTH-1];
        w_mag1 = w_s1 ? -bus.op1 : bus.op1;
        w_mag2 = w_s2 ? -bus.op2 : bus.op2;
        w_div0 = w_is_div && (bus.op2 == '0);
        // funct3[0]==0 selects the signed divide/remainder variants
        w_ovf  = w_is_div && !bus.funct3[0] && (bus.op1 == MIN_NEG) && (bus.op2 == '1);
    end

    // One shift-add multiply step: add multiplicand into the upper half when
    // the current multiplier bit (LSB) is set, then shift the product right.
    logic [WIDTH:0]      w_sum;
    logic [2*WIDTH-1:0]  w_prod_nx;

    always_comb begin
        w_sum     = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
        w_prod_nx = r_prod[0] ? {w_sum, r_prod[WIDTH-1:1]}
                              : {1'b0, r_prod[2*WIDTH-1:1]};
    end

    // One restoring divide step. r_rem[WIDTH] is always 0 after a step, but
    // folding it into the compare keeps the test correct for the full width.
    logic [WIDTH:0]      w_trial;
    logic [WIDTH:0]      w_diff;
    logic                w_ge;

    always_comb begin
        w_trial = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
        w_diff  = w_trial - {1'b0, r_dvs};
        w_ge    = r_rem[WIDTH] || (w_trial >= {1'b0, r_dvs});
    end

    // Sign fix-up and result selection
    logic [2*WIDTH-1:0]  w_prod_fix;
    logic [WIDTH-1:0]    w_quo_fix;
    logic [WIDTH-1:0]    w_rem_fix;
    logic [WIDTH-1:0]    w_final;

    always_comb begin
        w_prod_fix = r_neg_q ? -r_prod : r_prod;
        w_quo_fix  = r_neg_q ? -r_quo : r_quo;
        w_rem_fix  = r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
        w_final    = '0;
        case (r_op)
            F3_MUL:                   w_final = w_prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011:   w_final = w_prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:           w_final = w_quo_fix;
            default:                  w_final = w_rem_fix;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_op     <= '0;
            r_rd     <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_op    <= bus.funct3;
                        r_rd    <= bus.rd_in;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_mcand <= w_mag1;
                        r_prod  <= {{WIDTH{1'b0}}, w_mag2};
                        r_dvs   <= w_mag2;
                        r_quo   <= w_mag1;
                        r_rem   <= '0;
                        r_neg_q <= w_s1 ^ w_s2;
                        r_neg_r <= w_s1;
                        // Special divides preload quotient/remainder so the
                        // normal fix-up/selection yields the architected value.
                        if (w_div0) begin
                            r_quo   <= '1;
                            r_rem   <= {1'b0, bus.op1};
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                            r_state <= DONE;
                        end else if (w_ovf) begin
                            r_quo   <= MIN_NEG;
                            r_rem   <= '0;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                            r_state <= DONE;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_op[2]) begin
                        r_rem <= w_ge ? w_diff : w_trial;
                        r_quo <= {r_quo[WIDTH-2:0], w_ge};
                    end else begin
                        r_prod <= w_prod_nx;
                    end
                    if (r_cnt == CNT_W'(WIDTH-1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_result <= w_final;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.regwrite = r_done;
    assign bus.result   = r_result;
    assign bus.rd_out   = r_rd;

endmodule

// File: tb/tb_muldiv_unit.sv
// ----------------------------------------------------------------------------
// tb_muldiv_unit
//   Directed-vector bench for muldiv_unit with hand-computed expected results,
//   latency, busy duration, ignored restart and asynchronous abort.
// ----------------------------------------------------------------------------
module tb_muldiv_unit;
    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    muldiv_unit_if #(.WIDTH(32), .ADDR_W(5)) bus ();

    muldiv_unit #(.WIDTH(32), .ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one operation, scramble the inputs right after accept, then wait
    // (bounded) for done and check latency, busy duration and outputs.
    task automatic run_op(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp_res,
                          input int exp_lat);
        int k;
        int busy_cyc;
        bit seen;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.op1    = a;
        bus.op2    = b;
        bus.rd_in  = rd;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.funct3 = ~f3;
        bus.op1    = ~a;
        bus.op2    = ~b;
        bus.rd_in  = ~rd;
        k = 0;
        busy_cyc = 0;
        seen = 1'b0;
        while (!seen && k < 100) begin
            if (bus.busy) busy_cyc++;
            @(negedge clk);
            k++;
            seen = bus.done;
        end
        check({tag, "/done_seen"}, 32'(seen), 32'd1);
        check({tag, "/latency"}, k, exp_lat);
        check({tag, "/busy_cycles"}, busy_cyc, exp_lat);
        check({tag, "/result"}, bus.result, exp_res);
        check({tag, "/rd_out"}, 32'(bus.rd_out), 32'(rd));
        check({tag, "/regwrite"}, 32'(bus.regwrite), 32'd1);
        @(negedge clk);
        check({tag, "/done_clear"}, {30'd0, bus.done, bus.regwrite}, 32'd0);
    endtask

    initial begin
        int k;
        int rw_cnt;
        bit seen;
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.start  = 1'b0;
        bus.funct3 = '0;
        bus.op1    = '0;
        bus.op2    = '0;
        bus.rd_in  = '0;
        #2 rst = 1'b0;
        #1;
        check("reset/busy", 32'(bus.busy), 32'd0);
        check("reset/done", 32'(bus.done), 32'd0);
        check("reset/regwrite", 32'(bus.regwrite), 32'd0);
        check("reset/result", bus.result, 32'd0);
        check("reset/rd_out", 32'(bus.rd_out), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle/busy", 32'(bus.busy), 32'd0);

        run_op("mul_7_m3",      MUL,    32'd7,        32'hFFFF_FFFD, 5'd10, 32'hFFFF_FFEB, 33);
        run_op("mulhu_ones",    MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'hFFFF_FFFE, 33);
        run_op("mulh_ones",     MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'h0000_0000, 33);
        run_op("mulhsu_rd0",    MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFF, 33);
        run_op("div_m7_2",      DIV,    32'hFFFF_FFF9, 32'd2,        5'd13, 32'hFFFF_FFFD, 33);
        run_op("rem_m7_2",      REM,    32'hFFFF_FFF9, 32'd2,        5'd14, 32'hFFFF_FFFF, 33);
        run_op("divu_100_7",    DIVU,   32'd100,      32'd7,        5'd15, 32'd14,        33);
        run_op("remu_100_7",    REMU,   32'd100,      32'd7,        5'd16, 32'd2,         33);
        run_op("divu_big",      DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0,        33);
        run_op("divu_by0",      DIVU,   32'h0000_1234, 32'd0,        5'd18, 32'hFFFF_FFFF, 1);
        run_op("rem_by0",       REM,    32'h0000_1234, 32'd0,        5'd19, 32'h0000_1234, 1);
        run_op("div_neg_by0",   DIV,    32'hFFFF_FFF9, 32'd0,        5'd20, 32'hFFFF_FFFF, 1);
        run_op("rem_neg_by0",   REM,    32'hFFFF_FFF9, 32'd0,        5'd21, 32'hFFFF_FFF9, 1);
        run_op("div_ovf",       DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 32'h8000_0000, 1);
        run_op("rem_ovf",       REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd23, 32'h0000_0000, 1);

        // MUL 3*5 with a second start pulsed mid-calculation
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = MUL;
        bus.op1    = 32'd3;
        bus.op2    = 32'd5;
        bus.rd_in  = 5'd7;
        @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 100) begin
            if (k == 10) begin
                bus.start  = 1'b1;
                bus.funct3 = DIV;
                bus.op1    = 32'd100;
                bus.op2    = 32'd7;
                bus.rd_in  = 5'd3;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            k++;
            seen = bus.done;
        end
        bus.start = 1'b0;
        check("restart/done_seen", 32'(seen), 32'd1);
        check("restart/latency", k, 33);
        check("restart/result", bus.result, 32'd15);
        check("restart/rd_out", 32'(bus.rd_out), 32'd7);
        @(negedge clk);
        check("restart/no_queue", 32'(bus.busy), 32'd0);

        // Second operation aborted by reset mid-calculation
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = MUL;
        bus.op1    = 32'h0000_1234;
        bus.op2    = 32'h0000_0010;
        bus.rd_in  = 5'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        check("abort/busy_before", 32'(bus.busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("abort/busy", 32'(bus.busy), 32'd0);
        check("abort/done", 32'(bus.done), 32'd0);
        check("abort/result", bus.result, 32'd0);
        check("abort/rd_out", 32'(bus.rd_out), 32'd0);
        rw_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i == 3) rst = 1'b1;
            if (bus.regwrite) rw_cnt++;
        end
        check("abort/no_regwrite", rw_cnt, 0);
        check("abort/idle_after", 32'(bus.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
